// File: rtl/sni_match_pkg.sv
// Shared defaults and helpers for the SNI bitap pattern matcher.
package sni_match_pkg;

    localparam int unsigned DefLanes  = 4;
    localparam int unsigned DefPatLen = 16;
    localparam int unsigned DefOffW   = 16;
    localparam int unsigned MaxLanes  = 8;

    // Lane k of a beat of `lanes` bytes; lane 0 sits in the most significant byte.
    // The beat is passed zero-extended to the widest supported beat.
    function automatic logic [7:0] lane_byte(input logic [8*MaxLanes-1:0] data,
                                             input int unsigned lanes,
                                             input int unsigned k);
        return 8'(data >> (8 * (lanes - k - 1)));
    endfunction

    // Number of set bits in a keep vector (zero-extended to MaxLanes).
    function automatic logic [3:0] popcount(input logic [MaxLanes-1:0] keep);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < MaxLanes; i++) begin
            n = n + 4'(keep[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/sni_mask_table.sv
// 256-entry bitap mask table: one write port, one synchronous read port per lane.
// Each lane owns a full replica; all replicas take every write.
module sni_mask_table
    import sni_match_pkg::*;
#(
    parameter int unsigned LANES   = DefLanes,
    parameter int unsigned PAT_LEN = DefPatLen
) (
    input  logic                       i_clk,
    input  logic                       i_we,
    input  logic [7:0]                 i_waddr,
    input  logic [PAT_LEN-1:0]         i_wdata,
    input  logic [8*LANES-1:0]         i_raddr,   // lane k address at [8*k +: 8]
    output logic [PAT_LEN*LANES-1:0]   o_rdata    // lane k mask at [PAT_LEN*k +: PAT_LEN]
);

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        logic [PAT_LEN-1:0] mem [256];
        logic [PAT_LEN-1:0] rdata_q;

        // Replica write plus registered read; a same-cycle read returns the old entry.
        always_ff @(posedge i_clk) begin
            if (i_we) begin
                mem[i_waddr] <= i_wdata;
            end
            rdata_q <= mem[i_raddr[8*k +: 8]];
        end

        assign o_rdata[PAT_LEN*k +: PAT_LEN] = rdata_q;
    end

endmodule

// File: rtl/sni_bitap_matcher.sv
// Shift-and (bitap) matcher for SNI/hostname strings, LANES bytes per beat.
// Stage 0 looks up the mask table; stage 1 runs the lane chain, counter and frame flags.
module sni_bitap_matcher
    import sni_match_pkg::*;
#(
    parameter int unsigned LANES   = DefLanes,
    parameter int unsigned PAT_LEN = DefPatLen,
    parameter int unsigned OFF_W   = DefOffW
) (
    input  logic                             i_clk,
    input  logic                             i_rst,
    input  logic                             i_valid,
    input  logic [8*LANES-1:0]               i_data,
    input  logic [LANES-1:0]                 i_keep,
    input  logic                             i_sop,
    input  logic                             i_eop,
    input  logic                             i_cfg_we,
    input  logic [7:0]                       i_cfg_addr,
    input  logic [PAT_LEN-1:0]               i_cfg_wdata,
    input  logic [$clog2(PAT_LEN+1)-1:0]     i_cfg_len,
    output logic                             o_match,
    output logic [OFF_W-1:0]                 o_match_offset,
    output logic                             o_frame_done,
    output logic                             o_frame_hit
);

    localparam int unsigned LenW = $clog2(PAT_LEN + 1);
    localparam int unsigned CntW = OFF_W + 4;

    // Clamp a widened offset to the saturating counter range.
    function automatic logic [OFF_W-1:0] sat_off(input logic [CntW-1:0] x);
        return (x > CntW'({OFF_W{1'b1}})) ? '1 : x[OFF_W-1:0];
    endfunction

    // ---------------- Stage 0: table lookup and sideband register ----------------
    logic [8*LANES-1:0]         lane_addr;
    logic [PAT_LEN*LANES-1:0]   rd_mask;
    logic                       s1_valid_q;
    logic                       s1_sop_q;
    logic                       s1_eop_q;
    logic [LANES-1:0]           s1_keep_q;

    // Split the beat into per-lane table addresses.
    always_comb begin
        lane_addr = '0;
        for (int k = 0; k < LANES; k++) begin
            lane_addr[8*k +: 8] = lane_byte(64'(i_data), LANES, k);
        end
    end

    sni_mask_table #(
        .LANES   (LANES),
        .PAT_LEN (PAT_LEN)
    ) u_mask_table (
        .i_clk   (i_clk),
        .i_we    (i_cfg_we),
        .i_waddr (i_cfg_addr),
        .i_wdata (i_cfg_wdata),
        .i_raddr (lane_addr),
        .o_rdata (rd_mask)
    );

    // Sideband travels with the table read so both arrive at stage 1 together.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            s1_valid_q <= 1'b0;
            s1_sop_q   <= 1'b0;
            s1_eop_q   <= 1'b0;
            s1_keep_q  <= '0;
        end else begin
            s1_valid_q <= i_valid;
            s1_sop_q   <= i_sop;
            s1_eop_q   <= i_eop;
            s1_keep_q  <= i_keep;
        end
    end

    // ---------------- Stage 1: bitap chain, offset counter, frame flags ----------------
    logic [PAT_LEN-1:0]  d_q;
    logic [PAT_LEN-1:0]  d_d;
    logic [OFF_W-1:0]    cnt_q;
    logic [OFF_W-1:0]    cnt_d;
    logic                in_frame_q;
    logic                sticky_q;
    logic                sticky_base;
    logic                active;
    logic                found;
    logic [OFF_W-1:0]    first_off;
    logic [LenW-1:0]     eff_len;
    logic [PAT_LEN-1:0]  len_sel;
    logic [PAT_LEN-1:0]  d_lane;
    logic [CntW-1:0]     base;

    // Length 0 or beyond PAT_LEN means a full-width pattern; len_sel picks bit L-1.
    always_comb begin
        eff_len = i_cfg_len;
        if (i_cfg_len == '0 || 32'(i_cfg_len) > PAT_LEN) begin
            eff_len = LenW'(PAT_LEN);
        end
        len_sel = PAT_LEN'(1) << (eff_len - LenW'(1));
    end

    // Chain the lanes in order; the first matching lane supplies the reported offset.
    always_comb begin
        active      = s1_valid_q && (s1_sop_q || in_frame_q);
        sticky_base = sticky_q && !s1_sop_q;
        d_lane      = s1_sop_q ? '0 : d_q;
        base        = s1_sop_q ? '0 : CntW'(cnt_q);
        found       = 1'b0;
        first_off   = '0;
        for (int k = 0; k < LANES; k++) begin
            // keep is MSB-first like the data: lane k is bit LANES-1-k
            if (s1_keep_q[LANES-1-k]) begin
                d_lane = ((d_lane << 1) | PAT_LEN'(1)) & rd_mask[PAT_LEN*k +: PAT_LEN];
                if (!found && ((d_lane & len_sel) != '0)) begin
                    found     = 1'b1;
                    first_off = sat_off(base + CntW'(k));
                end
            end
        end
        d_d   = d_lane;
        cnt_d = sat_off(base + CntW'(popcount(MaxLanes'(s1_keep_q))));
    end

    // Commit state for accepted beats; outputs are one-cycle pulses.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            d_q            <= '0;
            cnt_q          <= '0;
            in_frame_q     <= 1'b0;
            sticky_q       <= 1'b0;
            o_match        <= 1'b0;
            o_match_offset <= '0;
            o_frame_done   <= 1'b0;
            o_frame_hit    <= 1'b0;
        end else begin
            o_match        <= 1'b0;
            o_match_offset <= '0;
            o_frame_done   <= 1'b0;
            o_frame_hit    <= 1'b0;
            if (active) begin
                d_q            <= d_d;
                cnt_q          <= cnt_d;
                sticky_q       <= sticky_base | found;
                in_frame_q     <= !s1_eop_q;
                o_match        <= found;
                o_match_offset <= first_off;
                o_frame_done   <= s1_eop_q;
                o_frame_hit    <= s1_eop_q && (sticky_base || found);
            end
        end
    end

endmodule

// File: tb/tb_sni_bitap_matcher.sv
// Self-checking bench for sni_bitap_matcher: byte-serial reference model feeding
// a scoreboard that is compared against the DUT outputs two cycles after each drive.
`timescale 1ns/1ps
module tb_sni_bitap_matcher;

    localparam int unsigned LANES   = 4;
    localparam int unsigned PAT_LEN = 16;
    localparam int unsigned OFF_W   = 6;
    localparam int unsigned LenW    = $clog2(PAT_LEN + 1);
    localparam int          OffMax  = (1 << OFF_W) - 1;

    logic                 i_clk = 1'b0;
    logic                 i_rst = 1'b1;
    logic                 i_valid = 1'b0;
    logic [31:0]          i_data = '0;
    logic [3:0]           i_keep = '0;
    logic                 i_sop = 1'b0;
    logic                 i_eop = 1'b0;
    logic                 i_cfg_we = 1'b0;
    logic [7:0]           i_cfg_addr = '0;
    logic [PAT_LEN-1:0]   i_cfg_wdata = '0;
    logic [LenW-1:0]      i_cfg_len = LenW'(5);
    logic                 o_match;
    logic [OFF_W-1:0]     o_match_offset;
    logic                 o_frame_done;
    logic                 o_frame_hit;

    sni_bitap_matcher #(
        .LANES   (LANES),
        .PAT_LEN (PAT_LEN),
        .OFF_W   (OFF_W)
    ) dut (
        .i_clk          (i_clk),
        .i_rst          (i_rst),
        .i_valid        (i_valid),
        .i_data         (i_data),
        .i_keep         (i_keep),
        .i_sop          (i_sop),
        .i_eop          (i_eop),
        .i_cfg_we       (i_cfg_we),
        .i_cfg_addr     (i_cfg_addr),
        .i_cfg_wdata    (i_cfg_wdata),
        .i_cfg_len      (i_cfg_len),
        .o_match        (o_match),
        .o_match_offset (o_match_offset),
        .o_frame_done   (o_frame_done),
        .o_frame_hit    (o_frame_hit)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        int               due;
        logic             match;
        logic [OFF_W-1:0] off;
        logic             done;
        logic             hit;
    } exp_t;

    exp_t sb[$];
    int   cyc      = 0;
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference model state
    logic [PAT_LEN-1:0] m_tab [256];
    logic [PAT_LEN-1:0] m_d      = '0;
    int                 m_cnt    = 0;
    bit                 m_in     = 1'b0;
    bit                 m_sticky = 1'b0;

    function automatic logic [31:0] str4(input string s);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < 4; i++) r[31-8*i -: 8] = s.getc(i);
        return r;
    endfunction

    // Monitor: compare every scoreboard entry that falls due this cycle.
    always begin
        exp_t e;
        @(posedge i_clk);
        #1;
        cyc++;
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            e = sb.pop_front();
            n_checks++;
            if (o_match !== e.match || o_frame_done !== e.done || o_frame_hit !== e.hit ||
                (e.match && o_match_offset !== e.off)) begin
                n_fail++;
                $display("FAIL beat_out cyc=%0d: got match=%b off=%0d done=%b hit=%b, want match=%b off=%0d done=%b hit=%b",
                         cyc, o_match, o_match_offset, o_frame_done, o_frame_hit,
                         e.match, e.off, e.done, e.hit);
            end
        end
    end

    // Drive one cycle and push the model's expected output for it.
    task automatic step(input bit v, input string s, input logic [3:0] keep,
                        input bit sop, input bit eop, input bit rst = 1'b0,
                        input bit we = 1'b0, input logic [7:0] wa = 8'h00,
                        input logic [PAT_LEN-1:0] wd = '0);
        exp_t        e;
        logic [31:0] data;
        logic [7:0]  b;
        int          len;
        @(negedge i_clk);
        data        = str4(s);
        i_rst       = rst;
        i_valid     = v;
        i_data      = data;
        i_keep      = keep;
        i_sop       = sop;
        i_eop       = eop;
        i_cfg_we    = we;
        i_cfg_addr  = wa;
        i_cfg_wdata = wd;
        len = (i_cfg_len == 0 || int'(i_cfg_len) > PAT_LEN) ? PAT_LEN : int'(i_cfg_len);
        e.due = cyc + 2; e.match = 1'b0; e.off = '0; e.done = 1'b0; e.hit = 1'b0;
        if (rst) begin
            for (int i = 0; i < sb.size(); i++) begin
                exp_t t;
                t = sb[i];
                t.match = 1'b0; t.done = 1'b0; t.hit = 1'b0;
                sb[i] = t;
            end
            m_d = '0; m_cnt = 0; m_in = 1'b0; m_sticky = 1'b0;
        end else if (v && (sop || m_in)) begin
            if (sop) begin
                m_d = '0; m_cnt = 0; m_sticky = 1'b0;
            end
            for (int k = 0; k < 4; k++) begin
                if (keep[3-k]) begin
                    b   = data[31-8*k -: 8];
                    m_d = ((m_d << 1) | PAT_LEN'(1)) & m_tab[b];
                    if (m_d[len-1] && !e.match) begin
                        e.match = 1'b1;
                        e.off   = OFF_W'(m_cnt);
                    end
                    if (m_cnt < OffMax) m_cnt++;
                end
            end
            m_sticky = m_sticky | e.match;
            e.done   = eop;
            e.hit    = eop && m_sticky;
            m_in     = !eop;
        end
        if (we) m_tab[wa] = wd;
        sb.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, "....", 4'h0, 1'b0, 1'b0);
    endtask

    task automatic prog(input logic [7:0] addr, input logic [PAT_LEN-1:0] mask);
        step(1'b0, "....", 4'h0, 1'b0, 1'b0, 1'b0, 1'b1, addr, mask);
    endtask

    task automatic load_pop3s();
        prog("p", 16'h0005);
        prog("o", 16'h0002);
        prog("3", 16'h0008);
        prog("s", 16'h0010);
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) step(1'b0, "....", 4'h0, 1'b0, 1'b0, 1'b1);
        idle(2);
        @(negedge i_clk);
        n_checks++;
        if ({o_match, o_match_offset, o_frame_done, o_frame_hit} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got match=%b off=%0d done=%b hit=%b, want all 0",
                     o_match, o_match_offset, o_frame_done, o_frame_hit);
        end
        for (int a = 0; a < 256; a++) prog(8'(a), '0);
    endtask

    task automatic test_basic();
        i_cfg_len = LenW'(5);
        load_pop3s();
        step(1'b1, "pop3", 4'b1111, 1'b1, 1'b1);
        step(1'b1, "xpop", 4'b1111, 1'b1, 1'b0);
        step(1'b1, "3s..", 4'b1111, 1'b0, 1'b1);
        idle(2);
    endtask

    task automatic test_span();
        step(1'b1, "zzpo", 4'b1111, 1'b1, 1'b0);
        step(1'b1, "p3sz", 4'b1111, 1'b0, 1'b1);
        step(1'b1, "zzpo", 4'b1111, 1'b1, 1'b0);
        idle(3);
        step(1'b1, "p3sz", 4'b1111, 1'b0, 1'b1);
        step(1'b1, "zpop", 4'b1111, 1'b1, 1'b0);
        step(1'b1, "3sss", 4'b1100, 1'b0, 1'b1);
        idle(2);
    endtask

    task automatic test_back_to_back();
        step(1'b1, "xxxx", 4'b1111, 1'b1, 1'b0);
        step(1'b1, "pop3", 4'b1111, 1'b0, 1'b1);
        step(1'b1, "s...", 4'b1111, 1'b1, 1'b1);
        idle(2);
    endtask

    task automatic test_reset_mid();
        step(1'b1, "zzpo", 4'b1111, 1'b1, 1'b0);
        step(1'b0, "....", 4'h0, 1'b0, 1'b0, 1'b1);
        step(1'b1, "p3sz", 4'b1111, 1'b0, 1'b1);
        step(1'b1, "pop3", 4'b1111, 1'b0, 1'b0);
        idle(2);
        @(negedge i_clk);
        n_checks++;
        if ({o_match, o_frame_done, o_frame_hit} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_mid_ignored: got match=%b done=%b hit=%b, want 0 0 0",
                     o_match, o_frame_done, o_frame_hit);
        end
        step(1'b1, "p3sz", 4'b1111, 1'b1, 1'b1);
        idle(2);
    endtask

    task automatic test_multi_match();
        prog("a", 16'h0001);
        idle(1);
        i_cfg_len = LenW'(1);
        idle(1);
        step(1'b1, "aaaa", 4'b1111, 1'b1, 1'b0);
        step(1'b1, "aaaa", 4'b1111, 1'b0, 1'b0, 1'b0, 1'b1, "a", 16'h0000);
        step(1'b1, "aaaa", 4'b1111, 1'b0, 1'b1);
        idle(2);
    endtask

    task automatic test_len_boundary();
        i_cfg_len = LenW'(0);
        idle(2);
        step(1'b1, "pop3", 4'b1111, 1'b1, 1'b0);
        step(1'b1, "s...", 4'b1000, 1'b0, 1'b1);
        idle(2);
        i_cfg_len = LenW'(4);
        idle(2);
        step(1'b1, "pop3", 4'b1111, 1'b1, 1'b1);
        idle(2);
        i_cfg_len = LenW'(5);
        idle(2);
    endtask

    task automatic test_saturate();
        step(1'b1, "zzzz", 4'b1111, 1'b1, 1'b0);
        for (int i = 0; i < 19; i++) step(1'b1, "zzzz", 4'b1111, 1'b0, 1'b0);
        step(1'b1, "pop3", 4'b1111, 1'b0, 1'b0);
        step(1'b1, "s...", 4'b1000, 1'b0, 1'b1);
        idle(2);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_span();
        test_back_to_back();
        test_reset_mid();
        test_multi_match();
        test_len_boundary();
        test_saturate();
        idle(3);
        repeat (3) @(posedge i_clk);
        #2;
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending entries, want 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sni_bitap_matcher.md
# sni_bitap_matcher

Parametrised shift-and (bitap) pattern matcher for SNI/hostname strings, processing LANES bytes per cycle against a runtime-programmable 256-entry mask table. It supersedes the fixed two-byte, fixed-table matchers. It sits in the SNI pattern-match path after payload extraction, and emits a per-beat match pulse with byte offset plus a per-frame hit summary.

## Interface
- LANES, 4, bytes processed per beat (1..8)
- PAT_LEN, 16, state-vector width = maximum pattern length
- OFF_W, 16, frame byte-offset counter width
- i_clk  in  1  clock
- i_rst  in  1  reset, synchronous, active-high
- i_valid  in  1  beat valid; no backpressure, every valid beat is accepted
- i_data  in  8*LANES  beat bytes; lane k = i_data[8*(LANES-k)-1 -: 8], lane 0 is earliest byte
- i_keep  in  LANES  lane k holds a byte; contiguous from lane 0
- i_sop  in  1  first beat of frame
- i_eop  in  1  last beat of frame
- i_cfg_we  in  1  mask-table write strobe
- i_cfg_addr  in  8  byte value being programmed
- i_cfg_wdata  in  PAT_LEN  mask: bit j = 1 if the byte may occupy pattern position j
- i_cfg_len  in  $clog2(PAT_LEN+1)  active pattern length; quasi-static
- o_match  out  1  pattern ended inside this beat
- o_match_offset  out  OFF_W  frame byte offset of the last pattern byte of the first match in the beat
- o_frame_done  out  1  pulse with the eop beat result
- o_frame_hit  out  1  valid with o_frame_done; 1 if any match occurred in the frame

## Operation
- Update per byte b: D = ((D << 1) | 1) & M[b]. Match when D[L-1] = 1, where L = i_cfg_len. A value of 0 or greater than PAT_LEN is treated as PAT_LEN.
- Lanes are chained combinationally in lane order within one beat. Lanes with keep = 0 leave D unchanged.
- Wildcard "?" and case folding are expressed in table contents only; there is no special logic for them.
- D persists across beats of a frame, so matches may span beats. On an sop beat, D is cleared to 0 before lane 0 is applied.
- Offset counter: cleared on sop, advances by popcount(keep) per beat, and saturates at 2^OFF_W-1.
- Multiple matches in one beat: o_match_offset reports the lowest lane.
- Sticky hit flag: set by any match, cleared on sop. An sop+eop beat is a one-beat frame; its own matches count.
- Beat without an open frame (no prior sop, or after eop): ignored, with no state change and no outputs. The in-frame flag is set by sop and cleared by eop.
- i_valid low mid-frame: all state is held.
- Table writes become visible to lookups issued on the cycle after the write. A same-cycle read returns old data. The table is not cleared by reset.
- Reset, including mid-frame: D = 0, offset = 0, in-frame = 0, sticky = 0, all outputs 0. The interrupted frame is discarded until the next sop.

## Timing
- Stage 0: lane bytes address the table, which has a 1-cycle synchronous read. Sideband signals (valid, keep, sop, eop) are registered alongside.
- Stage 1: chained update and offset compute. D, the counter and the outputs are registered.
- o_match, o_match_offset, o_frame_done and o_frame_hit appear 2 cycles after the accepted beat.
- Outputs are single-cycle pulses with no hold.
- Throughput: one beat per cycle, indefinitely.

## Structure
- Shared package sni_match_pkg holds:
  - the default LANES, PAT_LEN and OFF_W values;
  - the lane-extract function;
  - the popcount function.
- One sub-module, sni_mask_table: 256 x PAT_LEN, with one write port and LANES synchronous read ports. It is implemented as replicated RAMs, one per lane, all written in parallel.
- The top level contains the sideband pipeline, the bitap chain, the counter, the frame flags and the outputs.

## Test plan
- Program "pop3s" (L=5; p→bits 0 and 2, o→1, 3→3, s→4, all other bytes 0). Send a single sop+eop beat "pop3", keep=1111, then a frame "xpop3s.." over two beats → no match for "pop3"; match with offset 5, frame_hit = 1.
- Pattern spanning beats: beat 1 "zzpo" (sop), beat 2 "p3sz" (eop) → o_match on beat 2, offset 6.
- Idle cycles (i_valid = 0) inserted between those two beats → identical result. Partial final beat with keep=1100 holding "3s" → match, offset correct.
- Back-to-back frames: frame A ends "pop3" with eop, frame B starts "s..." with sop → no match in B, because D is cleared on sop.
- Reset asserted after beat 1 of a spanning match, followed by a beat without sop → all outputs 0, beat ignored.
- Two matches in one beat with L=1 (pattern "a", data "aaaa") → o_match = 1, offset = lane 0 offset. Rewrite the mask for 'a' to 0 mid-stream → no match from the next lookup on.
